// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared control-unit types: opcodes, ALU op codes, writeback selects and the
// MEM/WB control bundle, plus the funct3-to-ALU-op mapping shared by R/I decode.
package ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_UNDEF  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    read_en;
        logic    write_en;
        wb_sel_e wb_sel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUNDLE_NOP = '{reg_write: 1'b0, read_en: 1'b0,
                                           write_en: 1'b0, wb_sel: WB_ALU};

    // alt selects SUB over ADD and SRA over SRL (funct7[5] in R/I encodings)
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// DE/EX control bus between the datapath (master) and pipe_ctrl_unit (slave).
interface pipe_ctrl_unit_if #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
);
    logic               instr_valid;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic               br_taken;
    logic               dmem_ready;
    logic [ALUOP_W-1:0] alu_op;
    logic               sel_A;
    logic               sel_B;
    logic               fwd_a;
    logic               fwd_b;
    logic               pc_en;
    logic               flush_if;
    logic               read_en_mw;
    logic               write_en_mw;
    logic               reg_write_mw;
    logic [1:0]         wb_sel_mw;
    logic [REG_AW-1:0]  rd_mw;
    logic               illegal;
    logic               mem_timeout;

    modport master (
        output instr_valid, opcode, funct3, funct7, rd, rs1, rs2, br_taken, dmem_ready,
        input  alu_op, sel_A, sel_B, fwd_a, fwd_b, pc_en, flush_if, read_en_mw,
               write_en_mw, reg_write_mw, wb_sel_mw, rd_mw, illegal, mem_timeout
    );

    modport slave (
        input  instr_valid, opcode, funct3, funct7, rd, rs1, rs2, br_taken, dmem_ready,
        output alu_op, sel_A, sel_B, fwd_a, fwd_b, pc_en, flush_if, read_en_mw,
               write_en_mw, reg_write_mw, wb_sel_mw, rd_mw, illegal, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational RV32I decoder: instruction fields to ALU op, operand selects,
// MEM/WB control bundle, illegal flag and the PC-redirect request.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               br_taken,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               sel_a,
    output logic               sel_b,
    output logic               illegal,
    output logic               redirect,
    output ctrl_bundle_t       bundle
);
    alu_op_e op;
    logic    bad;

    always_comb begin
        op       = ALU_ADD;
        sel_a    = 1'b1;
        sel_b    = 1'b0;
        bad      = 1'b0;
        redirect = 1'b0;
        bundle   = BUNDLE_NOP;
        case (opcode)
            OP_R: begin
                sel_b            = 1'b1;
                bundle.reg_write = 1'b1;
                op  = alu_from_f3(funct3, funct7[5]);
                bad = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_I: begin
                bundle.reg_write = 1'b1;
                op = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    bad = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            end
            OP_L: begin
                bundle.reg_write = 1'b1;
                bundle.read_en   = 1'b1;
                bundle.wb_sel    = WB_LOAD;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_S: begin
                bundle.write_en = 1'b1;
                bad = (funct3 > 3'b010);
            end
            OP_B: begin
                sel_a    = 1'b0;
                redirect = br_taken;
                bad      = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LUI: begin
                op               = ALU_PASS_B;
                sel_a            = 1'b0;
                bundle.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                sel_a            = 1'b0;
                bundle.reg_write = 1'b1;
            end
            OP_JAL: begin
                sel_a            = 1'b0;
                redirect         = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.wb_sel    = WB_PC4;
            end
            OP_JALR: begin
                redirect         = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.wb_sel    = WB_PC4;
                bad              = (funct3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            op       = ALU_UNDEF;
            sel_a    = 1'b0;
            sel_b    = 1'b0;
            redirect = 1'b0;
            bundle   = BUNDLE_NOP;
        end
        illegal = bad;
        alu_op  = ALUOP_W'(op);
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// 3-stage RV32I control unit: decode, MEM/WB bundle register, forwarding,
// flush and dmem wait-state FSM. Define CTRL_PERF_CNT_EN for stall/flush counters.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    pipe_ctrl_unit_if.slave     bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

    state_e             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               mem_done;
    logic               timeout_q;
    ctrl_bundle_t       bundle_mw;
    ctrl_bundle_t       capture;
    logic [REG_AW-1:0]  rd_mw_q;
    logic [REG_AW-1:0]  rd_capture;

    ctrl_bundle_t       dec_bundle;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_sel_a;
    logic               dec_sel_b;
    logic               dec_illegal;
    logic               dec_redirect;

    logic               mem_active;
    logic               enter_wait;
    logic               advance;

    ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .opcode   (bus.opcode),
        .funct3   (bus.funct3),
        .funct7   (bus.funct7),
        .br_taken (bus.br_taken),
        .alu_op   (dec_alu_op),
        .sel_a    (dec_sel_a),
        .sel_b    (dec_sel_b),
        .illegal  (dec_illegal),
        .redirect (dec_redirect),
        .bundle   (dec_bundle)
    );

    // mem_done keeps a just-completed access from re-entering MEM_WAIT while
    // its bundle is still held for the one RUN cycle before advancing.
    assign mem_active = bundle_mw.read_en | bundle_mw.write_en;
    assign enter_wait = (state == RUN) && mem_active && !bus.dmem_ready && !mem_done;
    assign advance    = (state == RUN) && !enter_wait;
    assign cnt_next   = wait_cnt + 1'b1;

    always_comb begin
        capture    = BUNDLE_NOP;
        rd_capture = '0;
        if (bus.instr_valid && !dec_illegal) begin
            capture           = dec_bundle;
            capture.reg_write = dec_bundle.reg_write && (bus.rd != '0);
            rd_capture        = bus.rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_done  <= 1'b0;
            timeout_q <= 1'b0;
            bundle_mw <= BUNDLE_NOP;
            rd_mw_q   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (enter_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end else begin
                        mem_done  <= 1'b0;
                        bundle_mw <= capture;
                        rd_mw_q   <= rd_capture;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        state    <= RUN;
                        mem_done <= 1'b1;
                        wait_cnt <= '0;
                    end else if (cnt_next == CNT_W'(MAX_WAIT)) begin
                        state               <= RUN;
                        wait_cnt            <= '0;
                        timeout_q           <= 1'b1;
                        bundle_mw.read_en   <= 1'b0;
                        bundle_mw.write_en  <= 1'b0;
                        bundle_mw.reg_write <= 1'b0;
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.alu_op       = dec_alu_op;
    assign bus.sel_A        = dec_sel_a;
    assign bus.sel_B        = dec_sel_b;
    assign bus.illegal      = dec_illegal;
    assign bus.pc_en        = advance;
    assign bus.flush_if     = advance && bus.instr_valid && dec_redirect;
    assign bus.fwd_a        = bundle_mw.reg_write && (rd_mw_q != '0) && (rd_mw_q == bus.rs1);
    assign bus.fwd_b        = bundle_mw.reg_write && (rd_mw_q != '0) && (rd_mw_q == bus.rs2);
    assign bus.read_en_mw   = bundle_mw.read_en;
    assign bus.write_en_mw  = bundle_mw.write_en;
    assign bus.reg_write_mw = bundle_mw.reg_write;
    assign bus.wb_sel_mw    = bundle_mw.wb_sel;
    assign bus.rd_mw        = rd_mw_q;
    assign bus.mem_timeout  = timeout_q;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!advance)
                stall_cnt <= stall_cnt + 32'd1;
            if (bus.flush_if)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit with hand-computed expectations.
module tb_pipe_ctrl_unit;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    pipe_ctrl_unit_if #(.REG_AW(5), .ALUOP_W(4)) bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.funct3      = f3;
        bus.funct7      = f7;
        bus.rd          = rd;
        bus.rs1         = rs1;
        bus.rs2         = rs2;
    endtask

    task automatic bubble();
        bus.instr_valid = 1'b0;
        bus.opcode      = 7'b0010011;
        bus.funct3      = 3'b000;
        bus.funct7      = 7'b0000000;
        bus.rd          = 5'd0;
        bus.rs1         = 5'd0;
        bus.rs2         = 5'd0;
        bus.br_taken    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bubble();
        bus.dmem_ready = 1'b1;
        #2;
        total++; if (bus.reg_write_mw !== 1'b0) $display("FAIL rst_reg_write: got %0d want 0", bus.reg_write_mw); else passed++;
        total++; if (bus.read_en_mw !== 1'b0) $display("FAIL rst_read_en: got %0d want 0", bus.read_en_mw); else passed++;
        total++; if (bus.write_en_mw !== 1'b0) $display("FAIL rst_write_en: got %0d want 0", bus.write_en_mw); else passed++;
        total++; if (bus.rd_mw !== 5'd0) $display("FAIL rst_rd_mw: got %0d want 0", bus.rd_mw); else passed++;
        total++; if (bus.mem_timeout !== 1'b0) $display("FAIL rst_timeout: got %0d want 0", bus.mem_timeout); else passed++;
        total++; if (bus.pc_en !== 1'b1) $display("FAIL rst_pc_en: got %0d want 1", bus.pc_en); else passed++;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2);
        #1;
        total++; if (bus.alu_op !== 4'd0) $display("FAIL add_alu_op: got %0d want 0", bus.alu_op); else passed++;
        total++; if (bus.sel_A !== 1'b1) $display("FAIL add_sel_A: got %0d want 1", bus.sel_A); else passed++;
        total++; if (bus.sel_B !== 1'b1) $display("FAIL add_sel_B: got %0d want 1", bus.sel_B); else passed++;
        total++; if (bus.illegal !== 1'b0) $display("FAIL add_illegal: got %0d want 0", bus.illegal); else passed++;
        step();
        bubble();
        #1;
        total++; if (bus.reg_write_mw !== 1'b1) $display("FAIL add_reg_write_mw: got %0d want 1", bus.reg_write_mw); else passed++;
        total++; if (bus.rd_mw !== 5'd3) $display("FAIL add_rd_mw: got %0d want 3", bus.rd_mw); else passed++;
        total++; if (bus.wb_sel_mw !== 2'b00) $display("FAIL add_wb_sel: got %0d want 0", bus.wb_sel_mw); else passed++;
        step();
    endtask

    task automatic test_forward();
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd1, 5'd2);
        step();
        drive(7'b0110011, 3'b000, 7'b0100000, 5'd6, 5'd5, 5'd1);
        #1;
        total++; if (bus.alu_op !== 4'd1) $display("FAIL sub_alu_op: got %0d want 1", bus.alu_op); else passed++;
        total++; if (bus.fwd_a !== 1'b1) $display("FAIL fwd_a_hit: got %0d want 1", bus.fwd_a); else passed++;
        total++; if (bus.fwd_b !== 1'b0) $display("FAIL fwd_b_miss: got %0d want 0", bus.fwd_b); else passed++;
        step();
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd7, 5'd1, 5'd6);
        #1;
        total++; if (bus.fwd_b !== 1'b1) $display("FAIL fwd_b_hit: got %0d want 1", bus.fwd_b); else passed++;
        step();
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd0, 5'd1, 5'd2);
        step();
        drive(7'b0110011, 3'b000, 7'b0100000, 5'd6, 5'd0, 5'd1);
        #1;
        total++; if (bus.reg_write_mw !== 1'b0) $display("FAIL x0_reg_write_mw: got %0d want 0", bus.reg_write_mw); else passed++;
        total++; if (bus.fwd_a !== 1'b0) $display("FAIL x0_fwd_a: got %0d want 0", bus.fwd_a); else passed++;
        bubble();
        step();
        step();
    endtask

    task automatic test_load_wait();
        bus.dmem_ready = 1'b1;
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd7, 5'd1, 5'd0);
        #1;
        total++; if (bus.sel_B !== 1'b0) $display("FAIL lw_sel_B: got %0d want 0", bus.sel_B); else passed++;
        step();
        bubble();
        bus.dmem_ready = 1'b0;
        #1;
        total++; if (bus.pc_en !== 1'b0) $display("FAIL lw_t0_pc_en: got %0d want 0", bus.pc_en); else passed++;
        total++; if (bus.wb_sel_mw !== 2'b01) $display("FAIL lw_wb_sel: got %0d want 1", bus.wb_sel_mw); else passed++;
        for (int i = 1; i <= 2; i++) begin
            step();
            total++; if (bus.pc_en !== 1'b0 || bus.read_en_mw !== 1'b1)
                $display("FAIL lw_wait_%0d: pc_en=%0d read_en=%0d want 0/1", i, bus.pc_en, bus.read_en_mw);
            else passed++;
        end
        step();
        bus.dmem_ready = 1'b1;
        #1;
        total++; if (bus.pc_en !== 1'b0) $display("FAIL lw_ready_cycle_pc_en: got %0d want 0", bus.pc_en); else passed++;
        step();
        bus.dmem_ready = 1'b0;
        #1;
        total++; if (bus.pc_en !== 1'b1) $display("FAIL lw_release_pc_en: got %0d want 1", bus.pc_en); else passed++;
        total++; if (bus.read_en_mw !== 1'b1) $display("FAIL lw_release_read_en: got %0d want 1", bus.read_en_mw); else passed++;
        step();
        total++; if (bus.read_en_mw !== 1'b0) $display("FAIL lw_after_read_en: got %0d want 0", bus.read_en_mw); else passed++;
        total++; if (bus.mem_timeout !== 1'b0) $display("FAIL lw_no_timeout: got %0d want 0", bus.mem_timeout); else passed++;
        bus.dmem_ready = 1'b1;
    endtask

    task automatic test_timeout();
        int bad_cycles;
        bad_cycles = 0;
        bus.dmem_ready = 1'b1;
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd8, 5'd1, 5'd0);
        step();
        bubble();
        bus.dmem_ready = 1'b0;
        #1;
        total++; if (bus.pc_en !== 1'b0) $display("FAIL to_t0_pc_en: got %0d want 0", bus.pc_en); else passed++;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (bus.pc_en !== 1'b0 || bus.mem_timeout !== 1'b0 || bus.read_en_mw !== 1'b1)
                bad_cycles++;
        end
        total++; if (bad_cycles != 0) $display("FAIL to_wait_window: bad cycles got %0d want 0", bad_cycles); else passed++;
        step();
        total++; if (bus.mem_timeout !== 1'b1) $display("FAIL to_flag: got %0d want 1", bus.mem_timeout); else passed++;
        total++; if (bus.read_en_mw !== 1'b0) $display("FAIL to_read_en: got %0d want 0", bus.read_en_mw); else passed++;
        total++; if (bus.reg_write_mw !== 1'b0) $display("FAIL to_reg_write: got %0d want 0", bus.reg_write_mw); else passed++;
        total++; if (bus.pc_en !== 1'b1) $display("FAIL to_pc_en: got %0d want 1", bus.pc_en); else passed++;
        bus.dmem_ready = 1'b1;
        step();
        total++; if (bus.mem_timeout !== 1'b1) $display("FAIL to_sticky: got %0d want 1", bus.mem_timeout); else passed++;
    endtask

    task automatic test_branch();
        bus.dmem_ready = 1'b1;
        drive(7'b1100011, 3'b000, 7'b0000000, 5'd0, 5'd1, 5'd2);
        bus.br_taken = 1'b1;
        #1;
        total++; if (bus.flush_if !== 1'b1) $display("FAIL beq_flush: got %0d want 1", bus.flush_if); else passed++;
        total++; if (bus.alu_op !== 4'd0) $display("FAIL beq_alu_op: got %0d want 0", bus.alu_op); else passed++;
        step();
        drive(7'b1100011, 3'b000, 7'b0000000, 5'd0, 5'd1, 5'd2);
        bus.br_taken = 1'b0;
        #1;
        total++; if (bus.flush_if !== 1'b0) $display("FAIL beq_nt_flush: got %0d want 0", bus.flush_if); else passed++;
        total++; if (bus.reg_write_mw !== 1'b0) $display("FAIL beq_reg_write_mw: got %0d want 0", bus.reg_write_mw); else passed++;
        step();
        drive(7'b1101111, 3'b000, 7'b0000000, 5'd1, 5'd0, 5'd0);
        #1;
        total++; if (bus.flush_if !== 1'b1) $display("FAIL jal_flush: got %0d want 1", bus.flush_if); else passed++;
        step();
        bubble();
        #1;
        total++; if (bus.flush_if !== 1'b0) $display("FAIL jal_flush_one_cycle: got %0d want 0", bus.flush_if); else passed++;
        total++; if (bus.wb_sel_mw !== 2'b10) $display("FAIL jal_wb_sel: got %0d want 2", bus.wb_sel_mw); else passed++;
        total++; if (bus.rd_mw !== 5'd1) $display("FAIL jal_rd_mw: got %0d want 1", bus.rd_mw); else passed++;
        total++; if (bus.reg_write_mw !== 1'b1) $display("FAIL jal_reg_write: got %0d want 1", bus.reg_write_mw); else passed++;
        step();
    endtask

    task automatic test_stall_flush();
        bus.dmem_ready = 1'b1;
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd9, 5'd1, 5'd0);
        step();
        drive(7'b1100111, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd0);
        bus.dmem_ready = 1'b0;
        #1;
        total++; if (bus.flush_if !== 1'b0 || bus.pc_en !== 1'b0)
            $display("FAIL stall_flush_t0: flush=%0d pc_en=%0d want 0/0", bus.flush_if, bus.pc_en); else passed++;
        step();
        bus.dmem_ready = 1'b1;
        #1;
        total++; if (bus.flush_if !== 1'b0) $display("FAIL stall_flush_wait: got %0d want 0", bus.flush_if); else passed++;
        step();
        total++; if (bus.flush_if !== 1'b1 || bus.pc_en !== 1'b1)
            $display("FAIL stall_flush_release: flush=%0d pc_en=%0d want 1/1", bus.flush_if, bus.pc_en); else passed++;
        step();
        bubble();
        #1;
        total++; if (bus.wb_sel_mw !== 2'b10 || bus.rd_mw !== 5'd1)
            $display("FAIL jalr_bundle: wb_sel=%0d rd=%0d want 2/1", bus.wb_sel_mw, bus.rd_mw); else passed++;
        step();
    endtask

    task automatic test_illegal();
        bus.dmem_ready = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2);
        step();
        drive(7'b1111111, 3'b000, 7'b0000000, 5'd4, 5'd1, 5'd2);
        #1;
        total++; if (bus.illegal !== 1'b1) $display("FAIL ill_flag: got %0d want 1", bus.illegal); else passed++;
        total++; if (bus.alu_op !== 4'd15) $display("FAIL ill_alu_op: got %0d want 15", bus.alu_op); else passed++;
        total++; if (bus.reg_write_mw !== 1'b1) $display("FAIL ill_prev_reg_write: got %0d want 1", bus.reg_write_mw); else passed++;
        step();
        drive(7'b0100011, 3'b011, 7'b0000000, 5'd0, 5'd1, 5'd2);
        #1;
        total++; if (bus.reg_write_mw !== 1'b0 || bus.rd_mw !== 5'd0)
            $display("FAIL ill_zero_bundle: reg_write=%0d rd=%0d want 0/0", bus.reg_write_mw, bus.rd_mw); else passed++;
        total++; if (bus.illegal !== 1'b1) $display("FAIL ill_store_f3: got %0d want 1", bus.illegal); else passed++;
        step();
        total++; if (bus.write_en_mw !== 1'b0) $display("FAIL ill_store_write_en: got %0d want 0", bus.write_en_mw); else passed++;
        bubble();
        step();
    endtask

    task automatic test_reset_mid_wait();
        bus.dmem_ready = 1'b1;
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd9, 5'd1, 5'd0);
        step();
        bubble();
        bus.dmem_ready = 1'b0;
        step();
        total++; if (bus.read_en_mw !== 1'b1 || bus.pc_en !== 1'b0)
            $display("FAIL rmw_pre: read_en=%0d pc_en=%0d want 1/0", bus.read_en_mw, bus.pc_en); else passed++;
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus.read_en_mw !== 1'b0) $display("FAIL rmw_read_en: got %0d want 0", bus.read_en_mw); else passed++;
        total++; if (bus.reg_write_mw !== 1'b0) $display("FAIL rmw_reg_write: got %0d want 0", bus.reg_write_mw); else passed++;
        total++; if (bus.rd_mw !== 5'd0 || bus.wb_sel_mw !== 2'b00)
            $display("FAIL rmw_rd_wb: rd=%0d wb_sel=%0d want 0/0", bus.rd_mw, bus.wb_sel_mw); else passed++;
        total++; if (bus.mem_timeout !== 1'b0) $display("FAIL rmw_timeout: got %0d want 0", bus.mem_timeout); else passed++;
        total++; if (bus.pc_en !== 1'b1) $display("FAIL rmw_pc_en: got %0d want 1", bus.pc_en); else passed++;
        #1;
        rst = 1'b0;
        step();
        total++; if (bus.pc_en !== 1'b1 || bus.read_en_mw !== 1'b0)
            $display("FAIL rmw_after: pc_en=%0d read_en=%0d want 1/0", bus.pc_en, bus.read_en_mw); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_add();
        test_forward();
        test_load_wait();
        test_timeout();
        test_branch();
        test_stall_flush();
        test_illegal();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation control unit for the 3-stage RV32I core (IF | DE/EX | MEM/WB).
- Decodes the DE/EX instruction into a control bundle and registers it into the MEM/WB stage.
- Generates forwarding selects, taken-branch/jump flush, and a data-memory wait-state stall with a timeout.
- Adds, relative to the previous purely combinational decoder: store/branch no longer assert reg_write, plus LUI/AUIPC/JAL/JALR, illegal-opcode flag and sequential hazard handling.

Parameters:
- REG_AW, 5, register address width (4 gives RV32E; rd/rs with upper bits set are illegal).
- ALUOP_W, 4, ALU op width; must be >= 4.
- MAX_WAIT, 15, max dmem wait cycles before timeout; counter width is $clog2(MAX_WAIT+1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  DE/EX holds a valid instruction
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- rd, rs1, rs2  in  REG_AW each  register fields
- br_taken  in  1  branch comparator result for the DE/EX instruction
- dmem_ready  in  1  data memory completes the access this cycle
- alu_op  out  ALUOP_W  DE/EX ALU op (comb.)
- sel_A  out  1  1 = rs1, 0 = PC
- sel_B  out  1  1 = rs2, 0 = immediate
- fwd_a, fwd_b  out  1 each  select MEM/WB result for rs1/rs2
- pc_en  out  1  PC/IF register advance
- flush_if  out  1  replace the fetched instruction with a NOP
- read_en_mw, write_en_mw  out  1 each  dmem strobes (registered)
- reg_write_mw  out  1  register-file write enable
- wb_sel_mw  out  2  00 ALU, 01 load data, 10 PC+4
- rd_mw  out  REG_AW  writeback destination
- illegal  out  1  undefined instruction in DE/EX (comb.)
- mem_timeout  out  1  sticky timeout flag

Behaviour:
- ALU codes:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10 (LUI), undefined 15.
  - Loads, stores, AUIPC, JAL, JALR and branches use ADD.
- Decode, combinational:
  - Unknown opcode, or unknown funct3/funct7 combination: illegal=1, alu_op=15, all write/strobe controls 0.
  - Loads accept funct3 in {000,001,010,100,101}; stores accept {000,001,010}.
- Bundle register: on each advance, {reg_write, read_en, write_en, wb_sel, rd} is captured into the MEM/WB stage.
  - A zero bundle is captured instead when instr_valid=0 or illegal=1.
  - reg_write_mw is forced 0 when rd=0.
- Forwarding: fwd_a = reg_write_mw && rd_mw!=0 && rd_mw==rs1 (fwd_b likewise with rs2).
- FSM states RUN and MEM_WAIT:
  - RUN: if a MEM/WB access (read_en_mw|write_en_mw) is active and dmem_ready=0, go to MEM_WAIT.
  - MEM_WAIT: pc_en=0, the bundle is held, and the wait counter increments each cycle. dmem_ready=1 completes the access: return to RUN and advance next cycle.
  - Timeout: counter reaching MAX_WAIT sets mem_timeout and forces a return to RUN; the access is dropped by clearing read_en_mw/write_en_mw and reg_write_mw.
- Advance condition: state==RUN and not entering MEM_WAIT.
- Flush:
  - Taken branch (br_taken && branch opcode), JAL or JALR in DE/EX: flush_if=1 for exactly that cycle.
  - Flush is suppressed while stalled, and re-evaluated when the stall releases.
  - The flushing instruction itself proceeds normally.
- Simultaneous stall and flush: the stall wins.
- pc_en = advance.
- Reset (async): state RUN, counter 0, all *_mw outputs 0, rd_mw 0, mem_timeout 0.
- Reset asserted mid-MEM_WAIT aborts the access immediately; no strobe stays high after reset.
- Latency:
  - Control reaches MEM/WB 1 cycle after decode.
  - A dmem access costs 1 + wait cycles.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle pc_en=0; flush_cnt increments each cycle flush_if=1.
  - Both wrap at 2^32 and reset to 0.
- When undefined: no counters and no extra ports.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR);
  - the alu_op_e enum;
  - the wb_sel_e enum;
  - the ctrl_bundle_t struct.
- One sub-module: ctrl_decode, purely combinational, instruction fields to bundle + alu_op/sel/illegal.
- The FSM, forwarding and pipe register stay in pipe_ctrl_unit.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3) -> alu_op=0, sel_A=1, sel_B=1; next cycle reg_write_mw=1, rd_mw=3.
- ADD x5 followed by SUB x6,x5,x1 -> during SUB, fwd_a=1, fwd_b=0; same sequence with rd=x0 -> fwd_a=0.
- LW with dmem_ready low 3 cycles -> MEM_WAIT held 3 cycles, pc_en=0, read_en_mw held 1; advance on ready; no timeout.
- LW with dmem_ready stuck 0 -> mem_timeout=1 after 15 wait cycles, read_en_mw/reg_write_mw cleared, pc_en=1.
- BEQ with br_taken=1 -> flush_if=1 for one cycle, reg_write_mw=0; JAL x1 -> flush_if=1, wb_sel_mw=10, rd_mw=1.
- opcode 0x7F -> illegal=1, alu_op=15, zero bundle captured; rst pulsed during MEM_WAIT -> all *_mw outputs 0 asynchronously.
